// File: rtl/blob_pkg.sv
// Shared types and constants for the multi-channel blob hunter: FSM states,
// RGB333 field layout, accumulator width helpers and the colour-window match.
package blob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DIVIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned PIX_FW  = 9;
  localparam int unsigned FIELD_W = 3;
  localparam int unsigned R_LSB   = 6;
  localparam int unsigned G_LSB   = 3;
  localparam int unsigned B_LSB   = 0;

  localparam int unsigned DEF_H  = 240;
  localparam int unsigned DEF_V  = 240;
  localparam int unsigned DEF_CW = 10;

  function automatic int unsigned cnt_width(input int unsigned h, input int unsigned v);
    return $clog2(h * v + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_H, DEF_V);
  localparam int unsigned SUM_W = DEF_CW + CNT_W;

  function automatic logic field_in(input logic [PIX_FW-1:0] pix,
                                    input logic [PIX_FW-1:0] lo,
                                    input logic [PIX_FW-1:0] hi,
                                    input int unsigned       lsb);
    logic [FIELD_W-1:0] p, l, h;
    p = pix[lsb +: FIELD_W];
    l = lo[lsb +: FIELD_W];
    h = hi[lsb +: FIELD_W];
    return (p >= l) && (p <= h);
  endfunction

  // An inverted window (lo > hi) on any field can never be satisfied.
  function automatic logic pixel_match(input logic [PIX_FW-1:0] pix,
                                       input logic [PIX_FW-1:0] lo,
                                       input logic [PIX_FW-1:0] hi);
    return field_in(pix, lo, hi, R_LSB) &&
           field_in(pix, lo, hi, G_LSB) &&
           field_in(pix, lo, hi, B_LSB);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The first step is
// taken in the start cycle, so a result appears exactly SUM_W cycles later.
module seq_divider #(
  parameter int unsigned SUM_W = blob_pkg::SUM_W,
  parameter int unsigned CNT_W = blob_pkg::CNT_W,
  parameter int unsigned Q_W   = SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  rem_q, rem_d, dvs_q, dvs_d;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0] src_rem, src_dvs, diff;
  logic [SUM_W-1:0] src_quo;
  logic [CNT_W:0]   trial;
  logic             ge;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_rem, src_quo[SUM_W-1]};
    ge      = trial >= {1'b0, src_dvs};
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    diff    = trial[CNT_W-1:0] - src_dvs;

    step_d = step_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    done_d = 1'b0;

    if (clear) begin
      step_d = '0;
      rem_d  = '0;
      dvs_d  = '0;
      quo_d  = '0;
    end else if (start || (step_q != '0)) begin
      rem_d = ge ? diff : trial[CNT_W-1:0];
      quo_d = {src_quo[SUM_W-2:0], ge};
      if (start) begin
        dvs_d  = divisor;
        step_d = STEP_W'(SUM_W - 1);
        done_d = (SUM_W == 1);
      end else begin
        step_d = step_q - 1'b1;
        done_d = (step_q == STEP_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q[Q_W-1:0];

endmodule

// File: rtl/multi_blob_hunt.sv
// Raster-scans the frame buffer, accumulates per-channel colour-window hits and
// resolves centroids through one shared sequential divider.
module multi_blob_hunt
  import blob_pkg::*;
#(
  parameter int unsigned H_PIXELS  = 240,
  parameter int unsigned V_PIXELS  = 240,
  parameter int unsigned CW        = 10,
  parameter int unsigned PIX_W     = 9,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH*PIX_W-1:0] win_lo,
  input  logic [NUM_CH*PIX_W-1:0] win_hi,
  input  logic [PIX_W-1:0]        mem_pixel_data,
  output logic                    mem_request,
  output logic [CW-1:0]           mem_hcount,
  output logic [CW-1:0]           mem_vcount,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       found,
  output logic [NUM_CH*CW-1:0]    blob_x,
  output logic [NUM_CH*CW-1:0]    blob_y
);

  localparam int unsigned ACC_CNT_W = cnt_width(H_PIXELS, V_PIXELS);
  localparam int unsigned ACC_SUM_W = CW + ACC_CNT_W;
  localparam int unsigned NUM_OP    = 2 * NUM_CH;
  localparam int unsigned OP_W      = $clog2(NUM_OP + 1);
  localparam logic [MEM_LAT-1:0] TV_LAST = MEM_LAT'(1) << (MEM_LAT - 1);

  state_e state_q, state_d;
  logic [CW-1:0]           h_q, h_d, v_q, v_d;
  logic [NUM_CH*PIX_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [MEM_LAT-1:0]      tv_q, tv_d;
  logic [CW-1:0]           th_q [MEM_LAT];
  logic [CW-1:0]           th_d [MEM_LAT];
  logic [CW-1:0]           ty_q [MEM_LAT];
  logic [CW-1:0]           ty_d [MEM_LAT];

  logic [OP_W-1:0]         op_q, op_d, run_q, run_d;
  logic                    pend_q, pend_d;
  logic [CW-1:0]           res_q [NUM_OP];
  logic [CW-1:0]           res_d [NUM_OP];
  logic [NUM_CH-1:0]       found_q, found_d;
  logic [NUM_CH*CW-1:0]    bx_q, bx_d, by_q, by_d;

  logic                          abort_now, acc_en, acc_clr;
  logic [NUM_CH-1:0]             ok;
  logic [NUM_CH*ACC_SUM_W-1:0]   sum_x_flat, sum_y_flat;
  logic [NUM_CH*ACC_CNT_W-1:0]   cnt_flat;
  logic                          nxt_vld;
  logic [OP_W-1:0]               nxt_idx;
  logic                          div_start, div_done;
  logic [ACC_SUM_W-1:0]          div_dividend;
  logic [ACC_CNT_W-1:0]          div_divisor;
  logic [CW-1:0]                 div_quot;

  assign abort_now = abort && (state_q != ST_IDLE);
  assign acc_en    = tv_q[MEM_LAT-1];
  assign acc_clr   = abort_now || (state_q == ST_DONE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_SUM_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [ACC_CNT_W-1:0] n_q, n_d;
    logic                 hit;

    assign hit = pixel_match(mem_pixel_data, lo_q[c*PIX_W +: PIX_W], hi_q[c*PIX_W +: PIX_W]);

    always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      n_d  = n_q;
      if (acc_clr) begin
        sx_d = '0;
        sy_d = '0;
        n_d  = '0;
      end else if (acc_en && hit) begin
        sx_d = sx_q + ACC_SUM_W'(th_q[MEM_LAT-1]);
        sy_d = sy_q + ACC_SUM_W'(ty_q[MEM_LAT-1]);
        n_d  = n_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sx_q <= '0;
        sy_q <= '0;
        n_q  <= '0;
      end else begin
        sx_q <= sx_d;
        sy_q <= sy_d;
        n_q  <= n_d;
      end
    end

    assign ok[c] = n_q >= ACC_CNT_W'(MIN_COUNT);
    assign sum_x_flat[c*ACC_SUM_W +: ACC_SUM_W] = sx_q;
    assign sum_y_flat[c*ACC_SUM_W +: ACC_SUM_W] = sy_q;
    assign cnt_flat[c*ACC_CNT_W +: ACC_CNT_W]   = n_q;
  end

  // Lowest pending divide at or after op_q; under-threshold channels cost no cycles.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_idx = '0;
    for (int unsigned k = NUM_OP; k > 0; k--) begin
      if ((OP_W'(k - 1) >= op_q) && ok[(k-1)/2]) begin
        nxt_vld = 1'b1;
        nxt_idx = OP_W'(k - 1);
      end
    end
  end

  always_comb begin
    int unsigned ch;
    ch           = 32'(nxt_idx) >> 1;
    div_dividend = nxt_idx[0] ? sum_y_flat[ch*ACC_SUM_W +: ACC_SUM_W]
                              : sum_x_flat[ch*ACC_SUM_W +: ACC_SUM_W];
    div_divisor  = cnt_flat[ch*ACC_CNT_W +: ACC_CNT_W];
  end

  always_comb begin
    tv_d    = tv_q;
    tv_d[0] = (state_q == ST_SCAN);
    th_d[0] = h_q;
    ty_d[0] = v_q;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      th_d[i] = th_q[i-1];
      ty_d[i] = ty_q[i-1];
    end
    if (abort_now) tv_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    op_d      = op_q;
    run_d     = run_q;
    pend_d    = pend_q;
    res_d     = res_q;
    found_d   = found_q;
    bx_d      = bx_q;
    by_d      = by_q;
    div_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_SCAN;
          lo_d    = win_lo;
          hi_d    = win_hi;
          h_d     = '0;
          v_d     = '0;
        end
      end
      ST_SCAN: begin
        if (h_q == CW'(H_PIXELS - 1)) begin
          h_d = '0;
          if (v_q == CW'(V_PIXELS - 1)) begin
            v_d     = '0;
            state_d = ST_DRAIN;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tv_q == TV_LAST) state_d = ST_DIVIDE;
      end
      ST_DIVIDE: begin
        if (!pend_q || div_done) begin
          if (pend_q) res_d[run_q] = div_quot;
          if (nxt_vld) begin
            div_start = 1'b1;
            run_d     = nxt_idx;
            op_d      = nxt_idx + 1'b1;
            pend_d    = 1'b1;
          end else begin
            pend_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        op_d    = '0;
        found_d = ok;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ok[c]) begin
            bx_d[c*CW +: CW] = res_q[2*c];
            by_d[c*CW +: CW] = res_q[2*c+1];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_now) begin
      state_d   = ST_IDLE;
      h_d       = '0;
      v_d       = '0;
      op_d      = '0;
      pend_d    = 1'b0;
      div_start = 1'b0;
      found_d   = found_q;
      bx_d      = bx_q;
      by_d      = by_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      tv_q    <= '0;
      op_q    <= '0;
      run_q   <= '0;
      pend_q  <= 1'b0;
      found_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        th_q[i] <= '0;
        ty_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NUM_OP; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      tv_q    <= tv_d;
      th_q    <= th_d;
      ty_q    <= ty_d;
      op_q    <= op_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      found_q <= found_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
    end
  end

  seq_divider #(
    .SUM_W (ACC_SUM_W),
    .CNT_W (ACC_CNT_W),
    .Q_W   (CW)
  ) u_div (
    .clk      (clk),
    .rst_n    (reset_n),
    .clear    (abort_now),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign mem_request = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign mem_hcount  = h_q;
  assign mem_vcount  = v_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign found       = found_q;
  assign blob_x      = bx_q;
  assign blob_y      = by_q;

endmodule

// File: tb/tb_multi_blob_hunt.sv
// Directed bench for multi_blob_hunt on an 8x4 frame with a 2-cycle memory model.
module tb_multi_blob_hunt;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 10;
  localparam int PW = 9;
  localparam int NC = 3;
  localparam int ML = 2;
  localparam int MC = 4;

  localparam logic [PW-1:0] RED = 9'h1C0;
  localparam logic [PW-1:0] GRN = 9'h038;
  localparam logic [PW-1:0] LO0 = 9'h1C0;
  localparam logic [PW-1:0] LO1 = 9'h038;
  localparam logic [PW-1:0] LO2 = 9'h180;
  localparam logic [PW-1:0] HIA = 9'h1FF;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NC*PW-1:0]  win_lo = '0;
  logic [NC*PW-1:0]  win_hi = '0;
  logic [PW-1:0]     mem_pixel_data;
  logic              mem_request;
  logic [CW-1:0]     mem_hcount, mem_vcount;
  logic              busy, done;
  logic [NC-1:0]     found;
  logic [NC*CW-1:0]  blob_x, blob_y;

  logic [PW-1:0] frame [H*V];
  int a1 = 0;
  int a2 = 0;
  int total = 0;
  int bad = 0;

  multi_blob_hunt #(
    .H_PIXELS (H), .V_PIXELS (V), .CW (CW), .PIX_W (PW),
    .NUM_CH (NC), .MEM_LAT (ML), .MIN_COUNT (MC)
  ) dut (
    .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
    .win_lo (win_lo), .win_hi (win_hi), .mem_pixel_data (mem_pixel_data),
    .mem_request (mem_request), .mem_hcount (mem_hcount), .mem_vcount (mem_vcount),
    .busy (busy), .done (done), .found (found), .blob_x (blob_x), .blob_y (blob_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1 <= (int'(mem_vcount) % V) * H + (int'(mem_hcount) % H);
    a2 <= a1;
  end
  assign mem_pixel_data = frame[a2];

  task automatic clear_frame();
    for (int i = 0; i < H*V; i++) frame[i] = '0;
  endtask

  task automatic load_frame_a();
    clear_frame();
    frame[1]  = GRN; frame[5]  = GRN; frame[17] = GRN; frame[21] = GRN;
  endtask

  task automatic load_frame_b();
    clear_frame();
    frame[10] = RED; frame[12] = RED; frame[26] = RED; frame[28] = RED;
    frame[0]  = GRN; frame[7]  = GRN; frame[17] = GRN;
  endtask

  task automatic set_std_windows();
    win_lo = {LO2, LO1, LO0};
    win_hi = {HIA, HIA, HIA};
  endtask

  task automatic run_pass(input int s1, input int s2, input bit scramble,
                          output int lat, output int ndone);
    int k;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 1; lat = -1; ndone = 0;
    while (k < 400) begin
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 5) break;
      start = (k == s1) || (k == s2);
      if (scramble && k == 3) begin
        win_lo = '0;
        win_hi = '1;
      end
      @(posedge clk); #1; k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (mem_request !== 1'b0) begin bad++; $display("FAIL rst_memreq got %b want 0", mem_request); end
    total++; if (done !== 1'b0 || found !== '0) begin bad++; $display("FAIL rst_done_found got %b/%b want 0/0", done, found); end
    total++; if (blob_x !== '0 || blob_y !== '0) begin bad++; $display("FAIL rst_blob got %h/%h want 0/0", blob_x, blob_y); end
    @(negedge clk); reset_n = 1'b1;
    load_frame_b();
    set_std_windows();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    total++; if (mem_request !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midscan_rst req/busy got %b/%b want 0/0", mem_request, busy); end
    total++; if (mem_hcount !== '0 || mem_vcount !== '0) begin bad++; $display("FAIL midscan_rst count got %0d,%0d want 0,0", mem_hcount, mem_vcount); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    total++; if (mem_request !== 1'b1 || mem_hcount !== 10'd0 || mem_vcount !== 10'd0) begin
      bad++; $display("FAIL rescan_first req=%b h=%0d v=%0d want 1,0,0", mem_request, mem_hcount, mem_vcount); end
    @(posedge clk); #1;
    total++; if (mem_hcount !== 10'd1 || mem_vcount !== 10'd0) begin
      bad++; $display("FAIL rescan_second h=%0d v=%0d want 1,0", mem_hcount, mem_vcount); end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_abort busy got %b want 0", busy); end
  endtask

  task automatic test_prior_pass();
    int lat, nd;
    load_frame_a();
    set_std_windows();
    run_pass(0, 0, 1'b0, lat, nd);
    total++; if (lat !== 68) begin bad++; $display("FAIL prior_latency got %0d want 68", lat); end
    total++; if (nd !== 1) begin bad++; $display("FAIL prior_done_count got %0d want 1", nd); end
    total++; if (found !== 3'b010) begin bad++; $display("FAIL prior_found got %b want 010", found); end
    total++; if (blob_x !== {10'd0, 10'd3, 10'd0}) begin bad++; $display("FAIL prior_blob_x got %h want %h", blob_x, {10'd0, 10'd3, 10'd0}); end
    total++; if (blob_y !== {10'd0, 10'd1, 10'd0}) begin bad++; $display("FAIL prior_blob_y got %h want %h", blob_y, {10'd0, 10'd1, 10'd0}); end
  endtask

  task automatic test_threshold_overlap();
    int lat, nd;
    load_frame_b();
    set_std_windows();
    run_pass(0, 0, 1'b0, lat, nd);
    total++; if (lat !== 100) begin bad++; $display("FAIL main_latency got %0d want 100", lat); end
    total++; if (nd !== 1) begin bad++; $display("FAIL main_done_count got %0d want 1", nd); end
    total++; if (found !== 3'b101) begin bad++; $display("FAIL main_found got %b want 101", found); end
    total++; if (blob_x[9:0] !== 10'd3 || blob_y[9:0] !== 10'd2) begin
      bad++; $display("FAIL ch0_centroid got %0d,%0d want 3,2", blob_x[9:0], blob_y[9:0]); end
    total++; if (blob_x[19:10] !== 10'd3 || blob_y[19:10] !== 10'd1) begin
      bad++; $display("FAIL ch1_hold got %0d,%0d want 3,1", blob_x[19:10], blob_y[19:10]); end
    total++; if (blob_x[29:20] !== 10'd3 || blob_y[29:20] !== 10'd2) begin
      bad++; $display("FAIL ch2_overlap got %0d,%0d want 3,2", blob_x[29:20], blob_y[29:20]); end
  endtask

  task automatic test_abort_divide();
    int k, nd;
    load_frame_a();
    set_std_windows();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 1;
    while (k < 45) begin @(posedge clk); #1; k++; end
    total++; if (busy !== 1'b1 || mem_request !== 1'b0) begin
      bad++; $display("FAIL in_divide busy=%b req=%b want 1,0", busy, mem_request); end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle busy got %b want 0", busy); end
    nd = 0;
    repeat (120) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", nd); end
    total++; if (found !== 3'b101) begin bad++; $display("FAIL abort_found got %b want 101", found); end
    total++; if (blob_x !== {10'd3, 10'd3, 10'd3} || blob_y !== {10'd2, 10'd1, 10'd2}) begin
      bad++; $display("FAIL abort_blobs got %h/%h want %h/%h", blob_x, blob_y, {10'd3, 10'd3, 10'd3}, {10'd2, 10'd1, 10'd2}); end
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    load_frame_a();
    set_std_windows();
    run_pass(10, 50, 1'b1, lat, nd);
    total++; if (lat !== 68) begin bad++; $display("FAIL b2b_latency got %0d want 68", lat); end
    total++; if (nd !== 1) begin bad++; $display("FAIL b2b_done_count got %0d want 1", nd); end
    total++; if (found !== 3'b010) begin bad++; $display("FAIL b2b_found got %b want 010", found); end
    total++; if (blob_x !== {10'd3, 10'd3, 10'd3} || blob_y !== {10'd2, 10'd1, 10'd2}) begin
      bad++; $display("FAIL b2b_blobs got %h/%h want %h/%h", blob_x, blob_y, {10'd3, 10'd3, 10'd3}, {10'd2, 10'd1, 10'd2}); end
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_abort_idle busy got %b want 0", busy); end
    win_lo = {LO2, 9'h039, LO0};
    win_hi = {HIA, 9'h1F8, HIA};
    run_pass(0, 0, 1'b0, lat, nd);
    total++; if (lat !== 36) begin bad++; $display("FAIL none_found_latency got %0d want 36", lat); end
    total++; if (found !== 3'b000) begin bad++; $display("FAIL inverted_window_found got %b want 000", found); end
    total++; if (blob_x !== {10'd3, 10'd3, 10'd3} || blob_y !== {10'd2, 10'd1, 10'd2}) begin
      bad++; $display("FAIL none_found_hold got %h/%h want %h/%h", blob_x, blob_y, {10'd3, 10'd3, 10'd3}, {10'd2, 10'd1, 10'd2}); end
  endtask

  initial begin
    clear_frame();
    test_reset();
    test_prior_pass();
    test_threshold_overlap();
    test_abort_divide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
